// File: rtl/peak_detect_pkg.sv
// Shared definitions for the peak-detect sequencer.
//   - pdc_state_e : sequencer states (idle, arm, acquire, flush)
//   - PDC_*_W     : default datapath / divider / address widths
//   - MAX_LSB     : bit position of the max byte inside a packed {max,min} pair
//   - max_lsb()   : the same packing offset for a non-default sample width
package peak_detect_pkg;

  localparam int unsigned PDC_DATA_W = 8;
  localparam int unsigned PDC_DIV_W  = 16;
  localparam int unsigned PDC_ADDR_W = 10;

  // Max occupies the upper half of the packed pair.
  localparam int unsigned MAX_LSB = PDC_DATA_W;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArm   = 2'd1,
    StAcq   = 2'd2,
    StFlush = 2'd3
  } pdc_state_e;

  function automatic int unsigned max_lsb(input int unsigned data_w);
    return data_w;
  endfunction

endpackage

// File: rtl/pdc_hold_reg.sv
// One-entry valid/ready holding register between the capture logic and the
// sample-RAM write port, with address generation and overflow detection.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clr             start of a new acquisition: clears address, overflow, wrap
//   capture         a completed pair is presented on din this cycle
//   din             {max,min} pair to store
//   ready           sample RAM accepts the held pair
//   valid           a pair is held
//   data, addr      held pair and its RAM address (stable while stalled)
//   accept          valid && ready this cycle
//   at_top          held address is the last RAM location
//   wrapped         (PDC_RING_BUF_EN only) the address has wrapped to 0
//   ovf             sticky: a capture was dropped because the entry was busy
module pdc_hold_reg
  import peak_detect_pkg::*;
#(
  parameter int unsigned DATA_W = PDC_DATA_W,
  parameter int unsigned ADDR_W = PDC_ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                capture,
  input  logic [2*DATA_W-1:0] din,
  input  logic                ready,
  output logic                valid,
  output logic [2*DATA_W-1:0] data,
  output logic [ADDR_W-1:0]   addr,
  output logic                accept,
  output logic                at_top,
`ifdef PDC_RING_BUF_EN
  output logic                wrapped,
`endif
  output logic                ovf
);

  logic                valid_q;
  logic [2*DATA_W-1:0] data_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                ovf_q;
  logic                load;

  assign accept = valid_q && ready;
  assign at_top = (addr_q == {ADDR_W{1'b1}});
  // The entry can take a new pair when empty or when it drains this cycle.
  assign load   = capture && (!valid_q || ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      ovf_q   <= 1'b0;
    end else if (clr) begin
      addr_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      // Address always names the held pair, so it advances on every accept.
      if (accept) begin
        addr_q <= addr_q + ADDR_W'(1);
      end
      if (load) begin
        data_q  <= din;
        valid_q <= 1'b1;
      end else if (accept) begin
        valid_q <= 1'b0;
      end
      if (capture && valid_q && !ready) begin
        ovf_q <= 1'b1;
      end
    end
  end

`ifdef PDC_RING_BUF_EN
  logic wrapped_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wrapped_q <= 1'b0;
    end else if (accept && at_top) begin
      wrapped_q <= 1'b1;
    end
  end

  assign wrapped = wrapped_q;
`endif

  assign valid = valid_q;
  assign data  = data_q;
  assign addr  = addr_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/peak_detect_ctrl.sv
// Sequencer for the min/max peak-detect datapath. Drives the datapath clear
// and window-reload strobe, captures each finished {max,min} window and
// writes it to sample memory at incrementing addresses.
// Configuration macro: PDC_RING_BUF_EN -- when defined, the write address
// wraps at the top of memory (only STOP ends a run) and WRAPPED is present.
// Ports:
//   CLK, RST        acquisition clock, synchronous active-high reset
//   START, STOP     run control pulses
//   DIV             window length minus one, sampled on START
//   MAX_IN, MIN_IN  datapath results
//   MM_CLR_N        datapath clear (active low)
//   MM_EN           datapath reload strobe, high on the first sample of a window
//   WR_VALID/READY  sample-memory write handshake
//   WR_ADDR/DATA    pair address and {max,min} pair
//   BUSY, DONE      run in progress / end-of-run pulse
//   WRAPPED         (PDC_RING_BUF_EN only) address has wrapped
//   OVF             sticky dropped-pair flag
module peak_detect_ctrl
  import peak_detect_pkg::*;
#(
  parameter int unsigned DATA_W = PDC_DATA_W,
  parameter int unsigned DIV_W  = PDC_DIV_W,
  parameter int unsigned ADDR_W = PDC_ADDR_W
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                START,
  input  logic                STOP,
  input  logic [DIV_W-1:0]    DIV,
  input  logic [DATA_W-1:0]   MAX_IN,
  input  logic [DATA_W-1:0]   MIN_IN,
  output logic                MM_CLR_N,
  output logic                MM_EN,
  output logic                WR_VALID,
  input  logic                WR_READY,
  output logic [ADDR_W-1:0]   WR_ADDR,
  output logic [2*DATA_W-1:0] WR_DATA,
  output logic                BUSY,
  output logic                DONE,
`ifdef PDC_RING_BUF_EN
  output logic                WRAPPED,
`endif
  output logic                OVF
);

  localparam int unsigned MaxLsb = max_lsb(DATA_W);

  pdc_state_e          state_q;
  logic [DIV_W-1:0]    div_q;
  logic [DIV_W-1:0]    cnt_q;
  logic [DIV_W-1:0]    cnt_nxt;
  logic                first_q;
  logic                clr_n_q;
  logic                en_q;
  logic                busy_q;
  logic                done_q;

  logic [2*DATA_W-1:0] pair;
  logic                start_clr;
  logic                capture_raw;
  logic                capture;
  logic                full_accept;
  logic                drained;
  logic                hold_valid;
  logic                hold_accept;

  assign pair[MaxLsb +: DATA_W] = MAX_IN;
  assign pair[0 +: DATA_W]      = MIN_IN;

  assign start_clr   = (state_q == StIdle) && START;
  // At a reload cycle the datapath still shows the window that just ended;
  // the very first reload has no finished window behind it.
  assign capture_raw = (state_q == StAcq) && (cnt_q == '0) && !first_q;
  // Once the last RAM location is accepted no further pair may be stored.
  assign capture     = capture_raw && !full_accept;
  // Counter stays within 0..div_q, so an all-ones DIV cannot overflow it.
  assign cnt_nxt     = (cnt_q == div_q) ? '0 : cnt_q + DIV_W'(1);
  // Entry is empty now or empties at this edge (no captures while flushing).
  assign drained     = !hold_valid || hold_accept;

`ifdef PDC_RING_BUF_EN
  assign full_accept = 1'b0;
`else
  logic hold_at_top;
  assign full_accept = hold_accept && hold_at_top;
`endif

  pdc_hold_reg #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_hold (
    .clk     (CLK),
    .rst     (RST),
    .clr     (start_clr),
    .capture (capture),
    .din     (pair),
    .ready   (WR_READY),
    .valid   (hold_valid),
    .data    (WR_DATA),
    .addr    (WR_ADDR),
    .accept  (hold_accept),
`ifdef PDC_RING_BUF_EN
    .at_top  (),
    .wrapped (WRAPPED),
`else
    .at_top  (hold_at_top),
`endif
    .ovf     (OVF)
  );

  // Outputs are registered alongside the state so they line up with it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      div_q   <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
      clr_n_q <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (START) begin
            div_q   <= DIV;
            state_q <= StArm;
            clr_n_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        StArm: begin
          if (STOP) begin
            state_q <= StFlush;
          end else begin
            state_q <= StAcq;
            cnt_q   <= '0;
            first_q <= 1'b1;
            en_q    <= 1'b1;
          end
        end
        StAcq: begin
          if (full_accept) begin
            state_q <= StIdle;
            clr_n_q <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (STOP) begin
            state_q <= StFlush;
            en_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_nxt;
            en_q  <= (cnt_nxt == '0);
            if (cnt_q == '0) begin
              first_q <= 1'b0;
            end
          end
        end
        StFlush: begin
          if (drained) begin
            state_q <= StIdle;
            clr_n_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign MM_CLR_N = clr_n_q;
  assign MM_EN    = en_q;
  assign WR_VALID = hold_valid;
  assign BUSY     = busy_q;
  assign DONE     = done_q;

endmodule

// File: tb/tb_peak_detect_ctrl.sv
// Scoreboard bench for peak_detect_ctrl with a behavioural min/max datapath.
module tb_peak_detect_ctrl;

  typedef struct packed {
    logic [1:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic        STOP;
  logic [15:0] DIV;
  logic [7:0]  MAX_IN;
  logic [7:0]  MIN_IN;
  logic        MM_CLR_N;
  logic        MM_EN;
  logic        WR_VALID;
  logic        WR_READY;
  logic [1:0]  WR_ADDR;
  logic [15:0] WR_DATA;
  logic        BUSY;
  logic        DONE;
  logic        OVF;
`ifdef PDC_RING_BUF_EN
  logic        WRAPPED;
`endif

  logic [7:0]  sample;
  logic [7:0]  dmax;
  logic [7:0]  dmin;
  wr_t         exp_q[$];
  int          errors = 0;
  int          checks = 0;

  peak_detect_ctrl #(
    .DATA_W (8),
    .DIV_W  (16),
    .ADDR_W (2)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .START    (START),
    .STOP     (STOP),
    .DIV      (DIV),
    .MAX_IN   (MAX_IN),
    .MIN_IN   (MIN_IN),
    .MM_CLR_N (MM_CLR_N),
    .MM_EN    (MM_EN),
    .WR_VALID (WR_VALID),
    .WR_READY (WR_READY),
    .WR_ADDR  (WR_ADDR),
    .WR_DATA  (WR_DATA),
    .BUSY     (BUSY),
    .DONE     (DONE),
`ifdef PDC_RING_BUF_EN
    .WRAPPED  (WRAPPED),
`endif
    .OVF      (OVF)
  );

  always #5 CLK = ~CLK;

  // Datapath model: clear, reload on MM_EN, otherwise track min/max.
  always @(posedge CLK) begin
    if (!MM_CLR_N) begin
      dmax <= 8'h00;
      dmin <= 8'hFF;
    end else if (MM_EN) begin
      dmax <= sample;
      dmin <= sample;
    end else begin
      if (sample > dmax) dmax <= sample;
      if (sample < dmin) dmin <= sample;
    end
  end
  assign MAX_IN = dmax;
  assign MIN_IN = dmin;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void push(input logic [1:0] a, input logic [15:0] d);
    exp_q.push_back({a, d});
  endfunction

  // Caller is in an idle cycle; returns in the ARM cycle.
  task automatic start_run(input logic [15:0] d);
    START = 1'b1;
    DIV   = d;
    cyc();
    START = 1'b0;
    sample = 8'd0;
    chk("arm_busy", BUSY, 1);
    chk("arm_clr_n", MM_CLR_N, 1);
    chk("arm_en", MM_EN, 0);
    chk("arm_ovf_clr", OVF, 0);
  endtask

  // Monitor: every accepted write must match the head of the scoreboard.
  initial begin
    wr_t e;
    forever begin
      @(negedge CLK);
      if (WR_VALID === 1'b1 && WR_READY === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL wr_unexpected: got addr=%0d data=%h expected no write", WR_ADDR,
                   WR_DATA);
        end else begin
          e = exp_q.pop_front();
          if (WR_ADDR !== e.addr || WR_DATA !== e.data) begin
            errors++;
            $display("FAIL wr_pair: got addr=%0d data=%h expected addr=%0d data=%h", WR_ADDR,
                     WR_DATA, e.addr, e.data);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] ramp [8];
    ramp = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd5, 8'd6, 8'd7, 8'd8};
    RST = 1'b1; START = 1'b0; STOP = 1'b0; DIV = '0; WR_READY = 1'b1; sample = '0;
    cyc();
    cyc();
    chk("rst_clr_n", MM_CLR_N, 0);
    chk("rst_en", MM_EN, 0);
    chk("rst_valid", WR_VALID, 0);
    chk("rst_addr", WR_ADDR, 0);
    chk("rst_data", WR_DATA, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_ovf", OVF, 0);
    RST = 1'b0;
    cyc();

    // Basic window, DIV=3; a START mid-run must be ignored.
    push(2'd0, {8'd40, 8'd10});
    push(2'd1, {8'd8, 8'd5});
    start_run(16'd3);
    for (int i = 0; i < 8; i++) begin
      cyc();
      sample = ramp[i];
      chk("t1_mm_en", MM_EN, (i % 4 == 0) ? 1 : 0);
      START = (i == 2);
      DIV   = (i == 2) ? 16'd0 : 16'd3;
    end
    cyc();
    sample = 8'd0;
    STOP = 1'b1;
    chk("t1_mm_en_w3", MM_EN, 1);
    cyc();
    STOP = 1'b0;
    chk("t1_flush_busy", BUSY, 1);
    chk("t1_flush_en", MM_EN, 0);
    cyc();
    chk("t1_done", DONE, 1);
    chk("t1_busy_low", BUSY, 0);
    chk("t1_idle_clr_n", MM_CLR_N, 0);
    cyc();
    chk("t1_done_pulse", DONE, 0);
    chk("t1_q_empty", exp_q.size(), 0);

    // DIV=0: every sample is its own window.
    push(2'd0, {8'd7, 8'd7});
    push(2'd1, {8'd9, 8'd9});
    push(2'd2, {8'd3, 8'd3});
    start_run(16'd0);
    cyc(); sample = 8'd7; chk("t2_mm_en", MM_EN, 1);
    cyc(); sample = 8'd9; chk("t2_mm_en", MM_EN, 1);
    cyc(); sample = 8'd3;
    cyc(); sample = 8'd0; STOP = 1'b1;
    cyc(); STOP = 1'b0;
    cyc();
    chk("t2_done", DONE, 1);
    chk("t2_ovf", OVF, 0);
    cyc();
    chk("t2_q_empty", exp_q.size(), 0);

    // Backpressure, DIV=1: second capture dropped, OVF set.
    push(2'd0, {8'd2, 8'd1});
    push(2'd1, {8'd6, 8'd5});
    start_run(16'd1);
    cyc(); sample = 8'd1;
    cyc(); sample = 8'd2; WR_READY = 1'b0;
    cyc(); sample = 8'd3;
    cyc(); sample = 8'd4;
    chk("t3_valid", WR_VALID, 1);
    chk("t3_data", WR_DATA, 16'h0201);
    chk("t3_addr", WR_ADDR, 0);
    cyc(); sample = 8'd5;
    chk("t3_data_hold", WR_DATA, 16'h0201);
    chk("t3_addr_hold", WR_ADDR, 0);
    cyc(); sample = 8'd6;
    chk("t3_data_hold2", WR_DATA, 16'h0201);
    chk("t3_ovf", OVF, 1);
    cyc(); sample = 8'd7; WR_READY = 1'b1;
    cyc(); sample = 8'd8; STOP = 1'b1;
    chk("t3_next_addr", WR_ADDR, 1);
    chk("t3_next_data", WR_DATA, 16'h0605);
    cyc(); STOP = 1'b0;
    chk("t3_flush_empty", WR_VALID, 0);
    cyc();
    chk("t3_done", DONE, 1);
    chk("t3_ovf_sticky", OVF, 1);
    cyc();
    chk("t3_q_empty", exp_q.size(), 0);

    // STOP flush with a stalled pair; partial window discarded.
    push(2'd0, {8'd80, 8'd50});
    start_run(16'd3);
    cyc(); sample = 8'd50;
    cyc(); sample = 8'd60;
    cyc(); sample = 8'd70;
    cyc(); sample = 8'd80;
    cyc(); sample = 8'd1; WR_READY = 1'b0;
    cyc(); sample = 8'd2;
    chk("t4_valid", WR_VALID, 1);
    cyc(); sample = 8'd3; STOP = 1'b1;
    cyc(); STOP = 1'b0;
    chk("t4_flush_busy", BUSY, 1);
    chk("t4_flush_en", MM_EN, 0);
    chk("t4_flush_clr_n", MM_CLR_N, 1);
    cyc();
    cyc(); WR_READY = 1'b1;
    chk("t4_wait_done", DONE, 0);
    chk("t4_wait_busy", BUSY, 1);
    cyc();
    chk("t4_done", DONE, 1);
    chk("t4_busy_low", BUSY, 0);
    cyc();
    chk("t4_q_empty", exp_q.size(), 0);

    // Memory full (4 locations), DIV=0.
    push(2'd0, 16'h0101);
    push(2'd1, 16'h0202);
    push(2'd2, 16'h0303);
    push(2'd3, 16'h0404);
`ifdef PDC_RING_BUF_EN
    push(2'd0, 16'h0505);
    push(2'd1, 16'h0606);
`endif
    start_run(16'd0);
    for (int i = 1; i <= 6; i++) begin
      cyc();
      sample = 8'(i);
    end
    cyc();
`ifdef PDC_RING_BUF_EN
    chk("t5_wrapped", WRAPPED, 1);
    chk("t5_wrap_addr", WR_ADDR, 0);
    chk("t5_no_done", DONE, 0);
    sample = 8'd7;
    STOP = 1'b1;
    cyc();
    STOP = 1'b0;
    cyc();
    chk("t5_done", DONE, 1);
`else
    chk("t5_done", DONE, 1);
    chk("t5_busy_low", BUSY, 0);
    chk("t5_valid_low", WR_VALID, 0);
    cyc();
    chk("t5_done_pulse", DONE, 0);
`endif
    cyc();
    chk("t5_q_empty", exp_q.size(), 0);

    // Reset mid-ACQ with a pending pair.
    WR_READY = 1'b0;
    start_run(16'd0);
    cyc(); sample = 8'd9;
    cyc();
    cyc();
    chk("t6_pending", WR_VALID, 1);
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    WR_READY = 1'b1;
    chk("t6_clr_n", MM_CLR_N, 0);
    chk("t6_en", MM_EN, 0);
    chk("t6_valid", WR_VALID, 0);
    chk("t6_addr", WR_ADDR, 0);
    chk("t6_data", WR_DATA, 0);
    chk("t6_busy", BUSY, 0);
    chk("t6_done", DONE, 0);
    chk("t6_ovf", OVF, 0);
`ifdef PDC_RING_BUF_EN
    chk("t6_wrapped", WRAPPED, 0);
`endif
    cyc();
    chk("t6_done_after", DONE, 0);
    chk("t6_valid_after", WR_VALID, 0);
    cyc();
    chk("t6_q_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
